instr_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 28 ++
 rtl/instr_fetch_unit_pc_register.sv | 38 +++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// +----------------------------------------------------------------------+
// | fetch_pkg: shared types and constants for the instruction fetch unit |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  localparam int unsigned PC_INC           = 4;
  localparam logic [5:0]  HALT_OPCODE      = 6'b111111;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_HALT  = 3'd5
  } fetch_state_e;

  function automatic logic is_halt_word(input logic [31:0] word);
    return word[31:26] == HALT_OPCODE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_pc_register.sv
// +----------------------------------------------------------------------+
// | pc_register: program counter, redirect load has priority over +4    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_register
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;

  // The adder wraps naturally modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= load_val_i;
    end else if (inc_i) begin
      pc_q <= pc_q + ADDR_W'(PC_INC);
    end
  end

  assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// +----------------------------------------------------------------------+
// | instr_fetch_unit: MIPS fetch stage with branch redirect and drain.   |
// | Optional halt-on-opcode-111111 enabled by defining FETCH_HALT_EN.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              imem_req_q, instr_valid_q, halted_q;

  logic              pc_load, pc_inc, capture, halt_hit;
  logic [ADDR_W-1:0] target_aligned;
  logic              unused_tgt_lsbs;

  assign target_aligned  = {branch_target[ADDR_W-1:2], 2'b00};
  assign unused_tgt_lsbs = ^branch_target[1:0];

`ifdef FETCH_HALT_EN
  assign halt_hit = is_halt_word(imem_rdata);
`else
  assign halt_hit = 1'b0;
`endif

  // A redirect anywhere but HALT wins; the increment only matters when it does not.
  assign pc_load = branch_taken && (state_q != ST_HALT);
  assign pc_inc  = (state_q == ST_HOLD) && instr_ready;
  assign capture = (state_q == ST_WAIT) && imem_rvalid && !branch_taken;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (pc_load),
    .load_val_i (target_aligned),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_REQ;
      ST_REQ:   state_d = branch_taken ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (branch_taken) begin
          state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
        end else if (imem_rvalid) begin
          state_d = halt_hit ? ST_HALT : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (branch_taken || instr_ready) begin
          state_d = ST_REQ;
        end
      end
      // The stale response closes the drain even if a newer redirect lands with it.
      ST_DRAIN: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= (state_d == ST_REQ);
      instr_valid_q <= (state_d == ST_HOLD);
      halted_q      <= (state_d == ST_HALT);
      if (capture) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc;
      end
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// +----------------------------------------------------------------------+
// | tb_instr_fetch_unit: vector table, corner sequences, random + model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_unit;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, imem_rvalid, instr_ready, branch_taken;
  logic [31:0] imem_rdata, branch_target;
  logic        imem_req, instr_valid, halted;
  logic [31:0] imem_addr, instr, instr_pc;
  logic        imem_req2, instr_valid2, halted2;
  logic [31:0] imem_addr2, instr2, instr_pc2;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .halted(halted)
  );

  // Same stimulus, different reset PC: exercises the wrap from 0xFFFF_FFFC.
  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr2),
    .instr_pc(instr_pc2), .instr_valid(instr_valid2), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .halted(halted2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request-lifecycle reference model for dut (RESET_PC = 0).
  logic [31:0] m_pc, m_instr, m_ipc;
  bit m_start, m_issue, m_out, m_stale, m_full, m_halt;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    m_start = 1; m_issue = 0; m_out = 0; m_stale = 0; m_full = 0; m_halt = 0;
  endtask

  task automatic model_step();
    bit new_out, nx_issue, was_full;
    if (!rst_n) begin model_reset(); return; end
    if (m_halt) return;
    was_full = m_full;
    new_out  = m_issue || (m_out && !imem_rvalid);
    nx_issue = 0;
    if (branch_taken) begin
      m_pc     = {branch_target[31:2], 2'b00};
      m_full   = 0;
      m_stale  = new_out;
      nx_issue = !new_out;
    end else begin
      if (m_start) nx_issue = 1;
      if (m_out && imem_rvalid) begin
        if (m_stale) begin
          m_stale  = 0;
          nx_issue = 1;
        end else if (HALT_EN && imem_rdata[31:26] == 6'b111111) begin
          m_halt = 1;
        end else begin
          m_full = 1; m_instr = imem_rdata; m_ipc = m_pc;
        end
      end
      if (was_full && instr_ready) begin
        m_pc = m_pc + 32'd4; m_full = 0; nx_issue = 1;
      end
    end
    m_out = new_out; m_issue = nx_issue; m_start = 0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a * 32'h9E37_79B1) ^ 32'h1234_5678) & 32'hF7FF_FFFF;
  endfunction

  // Behavioural instruction memory used when auto_mem is set.
  bit          auto_mem = 0, rand_lat = 0, pend = 0;
  int          fixed_lat = 1, pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("req", imem_req, m_issue);
    if (m_issue) chk("addr", imem_addr, m_pc);
    chk("valid", instr_valid, m_full);
    if (m_full) begin
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
    end
    chk("halted", halted, m_halt);
    if (!rst_n) pend = 0;
    if (auto_mem) begin
      imem_rvalid = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr); pend = 0;
        end
      end
      if (imem_req) begin
        pend = 1; pend_addr = imem_addr;
        pend_cnt = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; pend = 0;
    tick();
    rst_n = 1'b1;
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);
  endtask

  typedef struct {
    logic rv; logic [31:0] rd; logic rdy; logic br; logic [31:0] tg;
    logic e_req; logic [31:0] e_addr; logic [31:0] e_addr2;
    logic e_valid; logic [31:0] e_instr; logic [31:0] e_ipc;
  } vec_t;

  function automatic vec_t mkv(logic rv, logic [31:0] rd, logic br, logic [31:0] tg,
                               logic e_req, logic [31:0] e_addr, logic [31:0] e_addr2,
                               logic e_valid, logic [31:0] e_instr, logic [31:0] e_ipc);
    vec_t v;
    v.rv = rv; v.rd = rd; v.rdy = 1'b1; v.br = br; v.tg = tg;
    v.e_req = e_req; v.e_addr = e_addr; v.e_addr2 = e_addr2;
    v.e_valid = e_valid; v.e_instr = e_instr; v.e_ipc = e_ipc;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    int n;
    logic [31:0] held_instr;

    // Cycle-by-cycle: 1-cycle memory, then branch+ready together in HOLD.
    tbl[0]  = mkv(0, 0,            0, 0,     0, 0,      0,            0, 0,            0);
    tbl[1]  = mkv(0, 0,            0, 0,     1, 32'h0,  32'hFFFF_FFFC, 0, 0,           0);
    tbl[2]  = mkv(1, 32'h2001_0001, 0, 0,    0, 0,      0,            0, 0,            0);
    tbl[3]  = mkv(0, 0,            0, 0,     0, 0,      0,            1, 32'h2001_0001, 32'h0);
    tbl[4]  = mkv(0, 0,            0, 0,     1, 32'h4,  32'h0,        0, 0,            0);
    tbl[5]  = mkv(1, 32'h8C22_0004, 0, 0,    0, 0,      0,            0, 0,            0);
    tbl[6]  = mkv(0, 0,            0, 0,     0, 0,      0,            1, 32'h8C22_0004, 32'h4);
    tbl[7]  = mkv(0, 0,            0, 0,     1, 32'h8,  32'h4,        0, 0,            0);
    tbl[8]  = mkv(1, 32'h1043_0010, 0, 0,    0, 0,      0,            0, 0,            0);
    tbl[9]  = mkv(0, 0,            1, 32'h40, 0, 0,     0,            1, 32'h1043_0010, 32'h8);
    tbl[10] = mkv(0, 0,            0, 0,     1, 32'h40, 32'h40,       0, 0,            0);
    tbl[11] = mkv(1, 32'hAC64_0000, 0, 0,    0, 0,      0,            0, 0,            0);
    tbl[12] = mkv(0, 0,            0, 0,     0, 0,      0,            1, 32'hAC64_0000, 32'h40);
    tbl[13] = mkv(0, 0,            0, 0,     1, 32'h44, 32'h44,       0, 0,            0);

    model_reset();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("v%0d_req", i), imem_req, tbl[i].e_req);
      chk($sformatf("v%0d_req2", i), imem_req2, tbl[i].e_req);
      if (tbl[i].e_req) begin
        chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
        chk($sformatf("v%0d_addr2", i), imem_addr2, tbl[i].e_addr2);
      end
      chk($sformatf("v%0d_valid", i), instr_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_instr", i), instr, tbl[i].e_instr);
        chk($sformatf("v%0d_ipc", i), instr_pc, tbl[i].e_ipc);
      end
      imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rd; instr_ready = tbl[i].rdy;
      branch_taken = tbl[i].br; branch_target = tbl[i].tg;
      tick();
    end
    imem_rvalid = 0; branch_taken = 0;

    // Latency 4 and a 5-cycle decode stall in HOLD.
    do_reset();
    auto_mem = 1; rand_lat = 0; fixed_lat = 4;
    n = 0;
    while (n < 20 && !instr_valid) begin tick(); n++; end
    chk("lat4_cycles_to_valid", n, 6);
    chk("lat4_instr", instr, mem_word(32'h0));
    held_instr = instr;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_instr", instr, held_instr);
      chk("stall_ipc", instr_pc, 32'h0);
      chk("stall_noreq", imem_req, 1'b0);
    end
    instr_ready = 1; tick(); instr_ready = 0;
    chk("adv_req", imem_req, 1'b1);
    chk("adv_addr", imem_addr, 32'h4);
    n = 0;
    while (n < 20 && !instr_valid) begin tick(); n++; end
    chk("adv_ipc", instr_pc, 32'h4);

    // Redirect in WAIT, stale response two cycles later.
    auto_mem = 0;
    do_reset();
    instr_ready = 1;
    tick();
    chk("drn_req0", imem_addr, 32'h0);
    tick();
    branch_taken = 1; branch_target = 32'h0000_0103;
    tick();
    branch_taken = 0;
    chk("drn_noreq", imem_req, 1'b0);
    tick();
    chk("drn_novalid", instr_valid, 1'b0);
    imem_rvalid = 1; imem_rdata = 32'h1111_2222;
    tick();
    imem_rvalid = 0;
    chk("drn_req", imem_req, 1'b1);
    chk("drn_addr", imem_addr, 32'h0000_0100);
    chk("drn_stale_valid", instr_valid, 1'b0);
    tick();
    imem_rvalid = 1; imem_rdata = 32'h3333_4444;
    tick();
    imem_rvalid = 0;
    chk("drn_new_valid", instr_valid, 1'b1);
    chk("drn_new_instr", instr, 32'h3333_4444);
    chk("drn_new_ipc", instr_pc, 32'h0000_0100);

    // Halt-opcode word.
    do_reset();
    instr_ready = 1;
    tick(); tick();
    imem_rvalid = 1; imem_rdata = 32'hFC00_0000;
    tick();
    imem_rvalid = 0;
`ifdef FETCH_HALT_EN
    chk("halt_set", halted, 1'b1);
    chk("halt_novalid", instr_valid, 1'b0);
    for (int k = 0; k < 6; k++) begin
      branch_taken = 1; branch_target = $urandom;
      tick();
      chk("halt_noreq", imem_req, 1'b0);
      chk("halt_stays", halted, 1'b1);
    end
    branch_taken = 0;
    do_reset();
    tick();
    chk("halt_resume_req", imem_req, 1'b1);
    chk("halt_resume_addr", imem_addr, 32'h0);
`else
    chk("fc_valid", instr_valid, 1'b1);
    chk("fc_instr", instr, 32'hFC00_0000);
    chk("fc_not_halted", halted, 1'b0);
`endif

    // Randomized traffic against the model.
    do_reset();
    auto_mem = 1; rand_lat = 1;
    for (int k = 0; k < 3000; k++) begin
      instr_ready   = ($urandom_range(0, 9) < 7);
      branch_taken  = ($urandom_range(0, 19) == 0);
      branch_target = $urandom;
      rst_n         = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1; branch_taken = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
